// File: rtl/regfile_sb.sv
// 32 x 32-bit register file fed by the WB writeback bus, with two bypassed read
// ports and a per-register pending-write scoreboard that ID uses for RAW detection.
module regfile_sb #(
  parameter bit BYPASS   = 1'b1,
  parameter int SB_CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [37:0] wb_to_rf_bus,
  input  logic        issue_we,
  input  logic [4:0]  issue_waddr,
  input  logic        flush,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic        busy1,
  output logic        busy2,
  output logic [31:0] wr_count,
  output logic        sb_overflow
);

  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

  // WB has no back-pressure: every beat on wb_to_rf_bus is consumed the cycle it appears.
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  assign {rf_we, rf_waddr, rf_wdata} = wb_to_rf_bus;

  logic [31:0]         regs [32];
  logic [SB_CNT_W-1:0] cnt  [32];

  logic        wb_commit;
  logic        issue_ok;
  logic        issue_sat;
  logic [31:0] inc_vec;
  logic [31:0] dec_vec;

  assign wb_commit = rf_we && (rf_waddr != 5'd0);
  assign issue_ok  = issue_we && (issue_waddr != 5'd0) && !flush;
  assign issue_sat = (cnt[issue_waddr] == CNT_MAX);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_ok && !issue_sat) inc_vec[issue_waddr] = 1'b1;
    if (wb_commit && (cnt[rf_waddr] != '0)) dec_vec[rf_waddr] = 1'b1;
  end

  // Read ports: r0 reads zero, then same-cycle WB forwarding, then the array.
  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == 5'd0) rdata1 = '0;
    else if (BYPASS && rf_we && (rf_waddr == raddr1)) rdata1 = rf_wdata;

    rdata2 = regs[raddr2];
    if (raddr2 == 5'd0) rdata2 = '0;
    else if (BYPASS && rf_we && (rf_waddr == raddr2)) rdata2 = rf_wdata;
  end

  // A register whose final pending write lands this cycle is forwarded, so not busy.
  always_comb begin
    busy1 = (raddr1 != 5'd0) && (cnt[raddr1] != '0) &&
            !(BYPASS && dec_vec[raddr1] && (cnt[raddr1] == CNT_ONE));
    busy2 = (raddr2 != 5'd0) && (cnt[raddr2] != '0) &&
            !(BYPASS && dec_vec[raddr2] && (cnt[raddr2] == CNT_ONE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      wr_count    <= '0;
      sb_overflow <= 1'b0;
    end else begin
      if (wb_commit) begin
        regs[rf_waddr] <= rf_wdata;
        wr_count       <= wr_count + 32'd1;
      end
      if (issue_ok && issue_sat) sb_overflow <= 1'b1;
      // cnt[0] is never touched here, so it stays at its reset value of zero.
      for (int r = 1; r < 32; r++) begin
        if (flush) begin
          cnt[r] <= '0;
        end else begin
          case ({inc_vec[r], dec_vec[r]})
            2'b10:   cnt[r] <= cnt[r] + CNT_ONE;
            2'b01:   cnt[r] <= cnt[r] - CNT_ONE;
            default: cnt[r] <= cnt[r];
          endcase
        end
      end
    end
  end

endmodule
